// File: rtl/tanh_pkg.sv
// Shared fixed-point constants and types for the Tanh forward/backward blocks.
// Activations are signed Q1.12; gradients carry 12 fractional bits.
package tanh_pkg;

  localparam int unsigned FRAC_BITS    = 12;
  localparam int unsigned ONE_Q        = 4096;
  localparam int unsigned TANH_Y_WIDTH = 13;
  localparam int unsigned GRAD_WIDTH   = 16;

  typedef logic signed [TANH_Y_WIDTH-1:0] act_q1_12_t;
  typedef logic signed [GRAD_WIDTH-1:0]   grad_t;

endpackage

// File: rtl/tanh_backward.sv
// Tanh backward pass: grad_in = (grad_out * (1 - y^2)) >>> 12, in a 3-stage pipeline
// with a single global stall driven by the output handshake.
module tanh_backward
  import tanh_pkg::*;
#(
  parameter int unsigned Y_WIDTH = TANH_Y_WIDTH,
  parameter int unsigned G_WIDTH = GRAD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      en,
  input  logic signed [Y_WIDTH-1:0] y,
  input  logic signed [G_WIDTH-1:0] grad_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [G_WIDTH-1:0] grad_in
);

  localparam int unsigned SqW = 2 * Y_WIDTH;
  localparam int unsigned DW  = 13;
  localparam int unsigned PW  = G_WIDTH + DW;

  logic                      advance;
  logic                      v1_q, v2_q, v3_q;
  logic                      en1_q, en2_q;
  logic signed [SqW-1:0]     sq_d, sq_q;
  logic signed [G_WIDTH-1:0] g1_q;
  logic        [DW-1:0]      d_d, d_q;
  logic signed [PW-1:0]      prod_d, prod_q;
  logic signed [G_WIDTH-1:0] grad_in_d, grad_in_q;

  assign advance   = !v3_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign grad_in   = grad_in_q;

  always_comb begin
    sq_d   = y * y;
    // y*y is never negative, so the shifted square is at most ONE_Q and d stays in 0..4096
    d_d    = DW'(ONE_Q - (sq_q >>> FRAC_BITS));
    // d is unsigned: zero-extend before the signed multiply
    prod_d = PW'(g1_q) * PW'($signed({1'b0, d_d}));
    // |grad_in| <= |grad_out| because d <= 1.0, so truncation never overflows
    grad_in_d = en2_q ? G_WIDTH'(prod_q >>> FRAC_BITS) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      grad_in_q <= '0;
    end else if (advance) begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      grad_in_q <= grad_in_d;
    end
  end

  // Data registers need no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      sq_q   <= sq_d;
      g1_q   <= grad_out;
      en1_q  <= en;
      d_q    <= d_d;
      prod_q <= prod_d;
      en2_q  <= en1_q;
    end
  end

  // d_q is kept as a stage register alongside the product for observability.
  logic unused_d;
  assign unused_d = ^d_q;

endmodule

// File: tb/tb_tanh_backward.sv
// Self-checking bench for tanh_backward: scoreboard queue filled on input transfer,
// drained and compared on output transfer.
module tb_tanh_backward;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               en;
  logic signed [12:0] y;
  logic signed [15:0] grad_out;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] grad_in;

  int vectors     = 0;
  int miscompares = 0;
  int rx_count    = 0;
  logic signed [15:0] exp_q[$];

  tanh_backward dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .en       (en),
    .y        (y),
    .grad_out (grad_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grad_in  (grad_in)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] model(input logic signed [12:0] yy,
                                               input logic signed [15:0] gg,
                                               input logic ee);
    int sq, d, p;
    sq = int'(yy) * int'(yy);
    d  = 4096 - (sq >>> 12);
    p  = int'(gg) * d;
    return ee ? 16'(p >>> 12) : 16'sd0;
  endfunction

  always @(negedge clk) begin : monitor
    logic signed [15:0] e;
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      rx_count++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output got %0d required no output", grad_in);
      end else begin
        e = exp_q.pop_front();
        if (grad_in !== e) begin
          miscompares++;
          $display("FAIL result got %0d required %0d", grad_in, e);
        end
      end
    end
  end

  task automatic send(input logic signed [12:0] yy, input logic signed [15:0] gg,
                      input logic ee, input logic signed [15:0] ex);
    int   n   = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    y        = yy;
    grad_out = gg;
    en       = ee;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(ex);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout got in_ready=0 required 1");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic measure(input logic signed [12:0] yy, input logic signed [15:0] gg,
                         input logic signed [15:0] ex);
    int lat = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    y         = yy;
    grad_out  = gg;
    en        = 1'b1;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL latency got %0d required 3", lat);
    end
    drain();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    en        = 1'b1;
    y         = '0;
    grad_out  = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || grad_in !== 16'sd0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b r=%b g=%0d required v=0 r=1 g=0",
               out_valid, in_ready, grad_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    measure(13'sd0, 16'sd1000, 16'sd1000);
  endtask

  task automatic test_values();
    int ys[5] = '{2085, 2085, 4095, -4096, 0};
    int gs[5] = '{4096, -1000, 1000, 12345, -32768};
    int ex[5] = '{3035, -741, 0, 0, -32768};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(13'(ys[i]), 16'(gs[i]), 1'b1, 16'(ex[i]));
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_en_gate();
    out_ready = 1'b1;
    send(13'sd0, 16'sd777, 1'b1, 16'sd777);
    send(13'sd100, 16'sd5000, 1'b0, 16'sd0);
    send(13'sd2085, 16'sd4096, 1'b1, 16'sd3035);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int                 idx = 0;
    int                 c   = 0;
    int                 rx0;
    logic signed [15:0] held;
    rx0 = rx_count;
    while ((idx < 10 || exp_q.size() != 0) && c < 60) begin
      out_ready = !(c >= 4 && c <= 6);
      if (idx < 10) begin
        in_valid = 1'b1;
        y        = 13'($urandom_range(0, 8191));
        grad_out = 16'($urandom);
        en       = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 3 && c <= 9) begin
        vectors++;
        if (in_ready !== out_ready) begin
          miscompares++;
          $display("FAIL stall_in_ready cycle %0d got %b required %b", c, in_ready, out_ready);
        end
      end
      if (c == 4) held = grad_in;
      if (c == 5 || c == 6) begin
        vectors++;
        if (grad_in !== held || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold cycle %0d got g=%0d v=%b required g=%0d v=1",
                   c, grad_in, out_valid, held);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(y, grad_out, en));
        idx++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (rx_count - rx0 !== 10 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_count got %0d required 10", rx_count - rx0);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b1;
    send(13'sd500, 16'sd1111, 1'b1, 16'sd0);
    send(13'sd600, 16'sd2222, 1'b1, 16'sd0);
    send(13'sd700, 16'sd3333, 1'b1, 16'sd0);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL inflight_valid got %b required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || grad_in !== 16'sd0) begin
      miscompares++;
      $display("FAIL async_reset got v=%b r=%b g=%0d required v=0 r=1 g=0",
               out_valid, in_ready, grad_in);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL stale_after_reset got %0d beats required 0", seen);
    end
    @(posedge clk);
    #1;
    measure(13'sd2085, -16'sd1000, -16'sd741);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_en_gate();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
